exe_pipe_stage: RTL and testbench

EXE_PIPE_STAGE -- requirements
Module: exe_pipe_stage

---
 rtl/exe_pipe_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_exe_pipe_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_pipe_stage.sv
// Execute stage: single-cycle ALU operations, an iterative shift-add
// multiplier (MUL/MLA) and a branch target adder, all feeding one
// registered output stage with stall/flush handling.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepting instructions; single-cycle ops complete here
// MUL    | shift-add iterations, MUL_STEP multiplier bits per cycle
// HOLD   | product ready but downstream stalled; wait to write it out
module exe_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              flush,
    input  logic              stall,
    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              I,
    input  logic              s_in,
    input  logic [3:0]        exe_command_in,
    input  logic [3:0]        imm_rotate,
    input  logic [3:0]        dest,
    input  logic [7:0]        imm_8,
    input  logic [23:0]       signed_immediate_24,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic [3:0]        status_reg_out,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              status_we_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        status_bits_out,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] branch_address
);

    localparam int N_ITER = DATA_W / MUL_STEP;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;

    // Control and side values of the multiply in flight, kept aligned
    // with the product until it is written out.
    logic              p_wb, p_mr, p_mw, p_swe;
    logic [3:0]        p_dest;
    logic [1:0]        p_cv;
    logic [DATA_W-1:0] p_rm;
    logic [DATA_W-1:0] p_br;

    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_b;
    logic              cin;
    logic              arith;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_y;
    logic              c_new, v_new;
    logic [DATA_W-1:0] br_next;

    logic              accept, is_mul, last_iter;
    logic              single_done, mul_done, hold_done, out_load;
    logic [DATA_W-1:0] partial, acc_sum, mul_res;

    assign ready_out = (state == S_IDLE) & ~stall & ~flush;
    assign accept    = valid_in & ready_out;
    assign is_mul    = (exe_command_in == OP_MUL) | (exe_command_in == OP_MLA);
    assign last_iter = (cnt == '0);

    assign br_next = PC_in + DATA_W'({{(DATA_W + 2){signed_immediate_24[23]}},
                                      signed_immediate_24, 2'b00});

    // Second operand selection: memory offset, rotated immediate or register.
    always_comb begin
        imm_ext = {{(DATA_W - 8){1'b0}}, imm_8};
        if (mem_read_in | mem_write_in)
            val2 = {{(DATA_W - 12){1'b0}}, imm_rotate, imm_8};
        else if (I)
            val2 = DATA_W'({imm_ext, imm_ext} >> {imm_rotate, 1'b0});
        else
            val2 = val_rm;
    end

    // Single-cycle ALU; add and subtract share one adder with inverted operand.
    always_comb begin
        op_b  = val2;
        cin   = 1'b0;
        arith = 1'b0;
        alu_y = val2;
        case (exe_command_in)
            OP_MVN: alu_y = ~val2;
            OP_ADD: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; cin = status_reg_out[1]; end
            OP_SUB: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
            OP_SBC: begin arith = 1'b1; op_b = ~val2; cin = status_reg_out[1]; end
            OP_AND: alu_y = val_rn & val2;
            OP_ORR: alu_y = val_rn | val2;
            OP_EOR: alu_y = val_rn ^ val2;
            default: alu_y = val2;
        endcase
        sum   = {1'b0, val_rn} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
        c_new = status_reg_out[1];
        v_new = status_reg_out[0];
        if (arith) begin
            alu_y = sum[DATA_W-1:0];
            c_new = sum[DATA_W];
            v_new = (val_rn[DATA_W-1] == op_b[DATA_W-1]) &&
                    (alu_y[DATA_W-1] != val_rn[DATA_W-1]);
        end
    end

    // One shift-add iteration and completion conditions.
    always_comb begin
        partial     = mcand * {{(DATA_W - MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};
        acc_sum     = acc + partial;
        mul_res     = (state == S_HOLD) ? acc : acc_sum;
        single_done = accept & ~is_mul;
        mul_done    = (state == S_MUL) & last_iter & ~stall & ~flush;
        hold_done   = (state == S_HOLD) & ~stall & ~flush;
        out_load    = single_done | mul_done | hold_done;
    end

    // Sequencer and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p_wb   <= 1'b0;
            p_mr   <= 1'b0;
            p_mw   <= 1'b0;
            p_swe  <= 1'b0;
            p_dest <= '0;
            p_cv   <= '0;
            p_rm   <= '0;
            p_br   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state  <= S_MUL;
                        cnt    <= CNT_LOAD;
                        mcand  <= val_rn;
                        mplier <= val_rs;
                        acc    <= (exe_command_in == OP_MLA) ? val_rm : '0;
                        p_wb   <= wb_en_in;
                        p_mr   <= mem_read_in;
                        p_mw   <= mem_write_in;
                        p_swe  <= s_in;
                        p_dest <= dest;
                        p_cv   <= status_reg_out[1:0];
                        p_rm   <= val_rm;
                        p_br   <= br_next;
                    end
                end
                S_MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    if (last_iter)
                        state <= stall ? S_HOLD : S_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_HOLD: begin
                    if (!stall)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: written on completion, held under stall, valid
    // dropped on flush or on an idle non-stalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out       <= 1'b0;
            wb_en_out       <= 1'b0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            status_we_out   <= 1'b0;
            dest_out        <= '0;
            status_bits_out <= '0;
            alu_res         <= '0;
            val_rm_out      <= '0;
            branch_address  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (out_load) begin
            valid_out <= 1'b1;
            if (single_done) begin
                wb_en_out       <= wb_en_in;
                mem_read_out    <= mem_read_in;
                mem_write_out   <= mem_write_in;
                status_we_out   <= s_in;
                dest_out        <= dest;
                status_bits_out <= {alu_y[DATA_W-1], alu_y == '0, c_new, v_new};
                alu_res         <= alu_y;
                val_rm_out      <= val_rm;
                branch_address  <= br_next;
            end else begin
                wb_en_out       <= p_wb;
                mem_read_out    <= p_mr;
                mem_write_out   <= p_mw;
                status_we_out   <= p_swe;
                dest_out        <= p_dest;
                status_bits_out <= {mul_res[DATA_W-1], mul_res == '0, p_cv};
                alu_res         <= mul_res;
                val_rm_out      <= p_rm;
                branch_address  <= p_br;
            end
        end else if (!stall) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_pipe_stage.sv
// Bench for exe_pipe_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_exe_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_out, flush, stall;
    logic        wb_en_in, mem_read_in, mem_write_in, I, s_in;
    logic [3:0]  exe_command_in, imm_rotate, dest, status_reg_out;
    logic [7:0]  imm_8;
    logic [23:0] signed_immediate_24;
    logic [31:0] PC_in, val_rn, val_rm, val_rs;
    logic        valid_out, wb_en_out, mem_read_out, mem_write_out, status_we_out;
    logic [3:0]  dest_out, status_bits_out;
    logic [31:0] alu_res, val_rm_out, branch_address;

    always #5 clk = ~clk;

    exe_pipe_stage #(.DATA_W(32), .MUL_STEP(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .flush(flush), .stall(stall), .wb_en_in(wb_en_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .I(I),
        .s_in(s_in), .exe_command_in(exe_command_in), .imm_rotate(imm_rotate),
        .dest(dest), .imm_8(imm_8), .signed_immediate_24(signed_immediate_24),
        .PC_in(PC_in), .val_rn(val_rn), .val_rm(val_rm), .val_rs(val_rs),
        .status_reg_out(status_reg_out), .valid_out(valid_out),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .status_we_out(status_we_out),
        .dest_out(dest_out), .status_bits_out(status_bits_out),
        .alu_res(alu_res), .val_rm_out(val_rm_out),
        .branch_address(branch_address)
    );

    typedef struct {
        logic        valid, wb, mr, mw, swe;
        logic [3:0]  dest, nzcv;
        logic [31:0] res, rm, br;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t m_out, m_pend;
    int   m_mul_left;
    bit   m_hold;
    bit   m_rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic out_t zero_out();
        out_t o;
        o.valid = 0; o.wb = 0; o.mr = 0; o.mw = 0; o.swe = 0;
        o.dest = 0; o.nzcv = 0; o.res = 0; o.rm = 0; o.br = 0;
        return o;
    endfunction

    // Architectural result of the instruction currently on the inputs.
    function automatic out_t model_exec();
        out_t        o;
        logic [31:0] v2, imm, r;
        logic [63:0] wide;
        logic        c, v, b;
        int          rot;
        imm = {24'h0, imm_8};
        rot = 2 * int'(imm_rotate);
        if (mem_read_in || mem_write_in) v2 = {20'h0, imm_rotate, imm_8};
        else if (I) v2 = (rot == 0) ? imm : ((imm >> rot) | (imm << (32 - rot)));
        else v2 = val_rm;
        c = status_reg_out[1];
        v = status_reg_out[0];
        b = !status_reg_out[1];
        case (exe_command_in)
            4'd9: r = ~v2;
            4'd2, 4'd3: begin
                wide = {32'h0, val_rn} + {32'h0, v2} +
                       ((exe_command_in == 4'd3) ? {63'h0, status_reg_out[1]} : 64'h0);
                r = wide[31:0];
                c = wide[32];
                v = (val_rn[31] == v2[31]) && (r[31] != val_rn[31]);
            end
            4'd4, 4'd5: begin
                if (exe_command_in == 4'd4) b = 1'b0;
                r = val_rn - v2 - {31'h0, b};
                c = ({32'h0, val_rn} >= ({32'h0, v2} + {63'h0, b}));
                v = (val_rn[31] != v2[31]) && (r[31] != val_rn[31]);
            end
            4'd6: r = val_rn & v2;
            4'd7: r = val_rn | v2;
            4'd8: r = val_rn ^ v2;
            4'd10, 4'd11: begin
                wide = {32'h0, val_rn} * {32'h0, val_rs};
                r = wide[31:0] + ((exe_command_in == 4'd11) ? val_rm : 32'h0);
            end
            default: r = v2;
        endcase
        o.valid = 1; o.wb = wb_en_in; o.mr = mem_read_in; o.mw = mem_write_in;
        o.swe = s_in; o.dest = dest; o.res = r; o.rm = val_rm;
        o.nzcv = {r[31], r == 32'h0, c, v};
        o.br = PC_in + {{6{signed_immediate_24[23]}}, signed_immediate_24, 2'b00};
        return o;
    endfunction

    // Advance the reference by one clock edge using the inputs it saw.
    task automatic model_tick(input bit rdy);
        out_t t;
        bit   done;
        done = 0;
        t = m_pend;
        if (rst) begin
            m_out = zero_out(); m_mul_left = 0; m_hold = 0;
        end else if (flush) begin
            m_out.valid = 0; m_mul_left = 0; m_hold = 0;
        end else begin
            if (rdy && valid_in) begin
                t = model_exec();
                if (exe_command_in == 4'd10 || exe_command_in == 4'd11) begin
                    m_pend = t; m_mul_left = 8;
                end else done = 1;
            end else if (m_mul_left > 0) begin
                m_mul_left--;
                if (m_mul_left == 0) begin
                    if (stall) m_hold = 1;
                    else begin t = m_pend; done = 1; end
                end
            end else if (m_hold && !stall) begin
                t = m_pend; done = 1; m_hold = 0;
            end
            if (done) m_out = t;
            else if (!stall) m_out.valid = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("valid_out", valid_out, m_out.valid);
        check_eq("wb_en_out", wb_en_out, m_out.wb);
        check_eq("mem_read_out", mem_read_out, m_out.mr);
        check_eq("mem_write_out", mem_write_out, m_out.mw);
        check_eq("status_we_out", status_we_out, m_out.swe);
        check_eq("dest_out", dest_out, m_out.dest);
        check_eq("status_bits_out", status_bits_out, m_out.nzcv);
        check_eq("alu_res", alu_res, m_out.res);
        check_eq("val_rm_out", val_rm_out, m_out.rm);
        check_eq("branch_address", branch_address, m_out.br);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        m_rdy = (m_mul_left == 0) && !m_hold && !stall && !flush;
        check_eq("ready_out", ready_out, m_rdy);
        @(posedge clk);
        model_tick(m_rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        valid_in = 0; flush = 0; stall = 0; wb_en_in = 0; mem_read_in = 0;
        mem_write_in = 0; I = 0; s_in = 0; exe_command_in = 0; imm_rotate = 0;
        dest = 0; imm_8 = 0; signed_immediate_24 = 0; PC_in = 0;
        val_rn = 0; val_rm = 0; val_rs = 0;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [31:0] rs);
        idle_inputs();
        valid_in = 1; exe_command_in = cmd; val_rn = rn; val_rm = rm; val_rs = rs;
        wb_en_in = 1; s_in = 1; dest = 4'hA;
    endtask

    initial begin
        int lows, pulses;
        logic [31:0] seen;
        m_out = zero_out(); m_pend = zero_out(); m_mul_left = 0; m_hold = 0;
        idle_inputs();
        status_reg_out = 4'h0;
        rst = 1;
        @(negedge clk);
        step();
        step();
        check_eq("rst_valid", valid_out, 1'b0);
        check_eq("rst_alu", alu_res, 32'h0);
        rst = 0;
        #1 check_eq("ready_after_rst", ready_out, 1'b1);
        step();

        issue(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h0);
        step();
        check_eq("add_ovf_res", alu_res, 32'h80000000);
        check_eq("add_ovf_nzcv", status_bits_out, 4'b1001);
        check_eq("add_ovf_valid", valid_out, 1'b1);

        issue(4'b0101, 32'd5, 32'd5, 32'h0);
        status_reg_out = 4'b0000;
        step();
        check_eq("sbc_res", alu_res, 32'hFFFFFFFF);
        check_eq("sbc_n", status_bits_out[3], 1'b1);
        check_eq("sbc_c", status_bits_out[1], 1'b0);

        issue(4'b0001, 32'h0, 32'h0, 32'h0);
        I = 1; imm_8 = 8'hFF; imm_rotate = 4'd4;
        step();
        check_eq("mov_rot_res", alu_res, 32'hFF000000);

        issue(4'b0010, 32'h0, 32'h0, 32'h0);
        signed_immediate_24 = 24'hFFFFFF; PC_in = 32'h100;
        step();
        check_eq("branch_neg", branch_address, 32'hFC);

        status_reg_out = 4'b0011;
        issue(4'b1010, 32'h1234, 32'h0, 32'h10);
        step();
        idle_inputs();
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            #1 if (!ready_out) lows++;
            step();
        end
        check_eq("mul_ready_low_cycles", lows, 8);
        check_eq("mul_res", alu_res, 32'h12340);
        check_eq("mul_cv_kept", status_bits_out[1:0], 2'b11);
        check_eq("mul_valid", valid_out, 1'b1);

        issue(4'b1011, 32'h11, 32'h5, 32'h101);
        step();
        idle_inputs();
        pulses = 0; seen = 0;
        for (int k = 1; k <= 16; k++) begin
            stall = (k >= 6 && k <= 12);
            step();
            if (valid_out) begin pulses++; seen = alu_res; end
        end
        check_eq("mla_hold_pulses", pulses, 1);
        check_eq("mla_hold_res", seen, 32'h1116);

        issue(4'b1010, 32'd5, 32'h0, 32'd7);
        step();
        idle_inputs();
        step();
        step();
        flush = 1;
        step();
        flush = 0;
        check_eq("flush_valid", valid_out, 1'b0);
        #1 check_eq("flush_ready", ready_out, 1'b1);
        issue(4'b0010, 32'd2, 32'd3, 32'h0);
        step();
        check_eq("post_flush_add", alu_res, 32'd5);
        check_eq("post_flush_valid", valid_out, 1'b1);

        issue(4'b1010, 32'd9, 32'h0, 32'd9);
        step();
        idle_inputs();
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        check_eq("rst_mul_valid", valid_out, 1'b0);
        check_eq("rst_mul_alu", alu_res, 32'h0);
        check_eq("rst_mul_wb", wb_en_out, 1'b0);
        step();

        for (int n = 0; n < 600; n++) begin
            valid_in = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 19) == 0);
            exe_command_in = 4'($urandom_range(0, 15));
            wb_en_in = 1'($urandom); s_in = 1'($urandom); I = 1'($urandom);
            mem_read_in = ($urandom_range(0, 9) == 0);
            mem_write_in = ($urandom_range(0, 9) == 0);
            imm_rotate = 4'($urandom); imm_8 = 8'($urandom); dest = 4'($urandom);
            signed_immediate_24 = 24'($urandom);
            PC_in = $urandom; val_rn = $urandom; val_rm = $urandom;
            val_rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (m_mul_left == 0 && !m_hold) status_reg_out = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
